rr_stream_mux: RTL and testbench
================================

Name: rr_stream_mux

Overview:
- Parametrised N:1 stream multiplexer with valid/ready handshake on every input and on the output.
- Selects one input channel per transfer and registers the winning word into a single output stage.
- Two modes: fixed select, where an external select picks the channel, and round-robin arbitration across all valid channels.
- Sits between several producer streams and one shared consumer, for example a shared bus or a serializer front-end.

Parameters:
- N, 4, number of input channels; legal range 2 to 16.
- W, 8, data width per channel in bits.
- SW, $clog2(N), select/index width; derived, not overridden.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SW  channel index used when mode=0.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel ready; one-hot or zero.
- out_valid  output  1  output register holds a word.
- out_data  output  W  registered data.
- out_sel  output  SW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer last=N-1, so channel 0 has first priority.
  - rst dominates any handshake occurring in the same cycle; a word held mid-operation is discarded.
- Output stage free: free = !out_valid || out_ready (combinational). A full output being drained in this cycle counts as free.
- Grant selection is combinational and only evaluated when free=1.
  - mode=0: grant = sel if in_valid[sel]=1. Otherwise no grant. sel >= N gives no grant.
  - mode=1: grant = first i with in_valid[i]=1, scanning last+1, last+2, ... mod N. If no input is valid, no grant.
- in_ready[grant]=1 only when free=1 and a grant exists. All other bits are 0. in_ready never depends on out_valid alone beyond the free term.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. On the next edge:
  - out_valid=1.
  - out_data = in_data[g*W +: W].
  - out_sel = g.
  - last = g, only when mode=1. In mode 0, last is unchanged.
- Latency: 1 cycle from input transfer to out_valid. Sustained throughput is 1 word/cycle while out_ready=1.
- No grant while free=1 and out_ready=1: on the next edge out_valid=0, and out_data/out_sel hold their old values.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data and out_sel are stable.
  - All in_ready bits are 0.
- mode/sel changes:
  - Sampled only during arbitration.
  - Never alter a word already held in the output register.
  - Take effect on the next free cycle.
- Fairness (mode=1): with all N channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0. No channel waits more than N-1 transfers once valid.
- No state machine beyond the output register and the last pointer. Total state is out_valid, out_data, out_sel, last.
- No word is dropped or duplicated. Every input transfer produces exactly one output transfer.

Test Plan:
- Reset: assert rst 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000 during reset. The first grant after reset (mode=1) is channel 0.
- Fixed mode: mode=0, sel=2, in_data={8'h44,8'h33,8'h22,8'h11}, in_valid=1111, out_ready=1 -> in_ready=0100 every cycle. Each cycle after the first: out_data=8'h33, out_sel=2. Setting sel=2 with in_valid=1011 -> in_ready=0000 and out_valid drops to 0.
- Round-robin: mode=1, in_valid=1111, out_ready=1, data as above -> out_sel sequence 0,1,2,3,0 with out_data 11,22,33,44,11.
- Sparse round-robin: in_valid=1010 constant -> out_sel alternates 1,3,1,3. Then in_valid=0001 -> out_sel=0 within 1 cycle.
- Backpressure: fill output from channel 1 (out_data=8'h22), hold out_ready=0 for 5 cycles while changing in_data and sel -> out_data stays 8'h22, out_sel stays 1, in_ready=0000. Raising out_ready -> a new word is accepted in that same cycle.
- Reset mid-operation: out_valid=1 with out_ready=0, then pulse rst -> next cycle out_valid=0 and last=N-1. The next round-robin grant is channel 0 even if the previous grant was 2.

Source files
------------

// File: rtl/rr_stream_mux.sv
// rr_stream_mux
//   N:1 valid/ready stream multiplexer with a single registered output stage.
//   mode=0 takes the channel named by sel. mode=1 arbitrates round-robin,
//   starting the scan just after the last channel granted in that mode.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used when mode=0
//   in_valid   per-channel valid
//   in_data    packed channel data, channel i at [i*W +: W]
//   in_ready   per-channel ready, one-hot or zero
//   out_valid  output register holds a word
//   out_data   registered word
//   out_sel    channel that supplied out_data
//   out_ready  consumer accepts the word
module rr_stream_mux #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  input  logic            out_ready
);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_sel_q,   out_sel_d;
  logic [SW-1:0] last_q,      last_d;

  logic          free;
  logic          fix_ok;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic [SW-1:0] cand;
  logic          grant_valid;
  logic [SW-1:0] grant;
  logic [W-1:0]  word;

  // A full register being drained this cycle can take a new word.
  assign free = !out_valid_q || out_ready;

  // Out-of-range sel simply yields no grant.
  assign fix_ok = (32'(sel) < 32'(N)) && in_valid[sel];

  // Scan last+1, last+2, ... wrapping; first valid channel wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand = SW'((32'(last_q) + 32'(k)) % 32'(N));
      if (!rr_found && in_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Reset blocks any handshake in the same cycle.
  assign grant_valid = free && !rst && (mode ? rr_found : fix_ok);
  assign grant       = mode ? rr_idx : sel;

  always_comb begin
    in_ready = '0;
    word     = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) begin
        in_ready[i] = grant_valid;
        word        = in_data[i*W +: W];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    if (grant_valid) begin
      out_valid_d = 1'b1;
      out_data_d  = word;
      out_sel_d   = grant;
      // Only round-robin grants move the fairness pointer.
      if (mode) begin
        last_d = grant;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_q      <= SW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
module tb_rr_stream_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic [1:0]   sel;
  logic [3:0]   in_valid;
  logic [31:0]  in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_stream_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  // Inputs for one cycle; eir is in_ready during that cycle,
  // eov/eod/eos are the registered outputs after the following edge.
  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  v;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  eir;
    logic        eov;
    logic [7:0]  eod;
    logic [1:0]  eos;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] D  = 32'h44332211;
  localparam logic [31:0] D2 = 32'hAABBCCDD;

  task automatic add(input logic r, input logic m, input logic [1:0] s,
                     input logic [3:0] v, input logic [31:0] d, input logic o,
                     input logic [3:0] eir, input logic eov,
                     input logic [7:0] eod, input logic [1:0] eos);
    vec_t e;
    e.rst = r; e.mode = m; e.sel = s; e.v = v; e.d = d; e.ordy = o;
    e.eir = eir; e.eov = eov; e.eod = eod; e.eos = eos;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic m, input logic [1:0] s,
                       input logic [3:0] v, input logic [31:0] d, input logic o);
    rst = r; mode = m; sel = s; in_valid = v; in_data = d; out_ready = o;
  endtask

  initial begin
    int got;
    drive(1'b1, 1'b1, 2'd0, 4'hF, D, 1'b1);

    //   rst mode sel v     data ordy  eir   eov eod    eos
    // reset with everything valid
    add(1, 1, 0, 4'hF, D,  1, 4'h0, 0, 8'h00, 0);
    add(1, 1, 0, 4'hF, D,  1, 4'h0, 0, 8'h00, 0);
    // round-robin, all valid
    add(0, 1, 0, 4'hF, D,  1, 4'h1, 1, 8'h11, 0);
    add(0, 1, 0, 4'hF, D,  1, 4'h2, 1, 8'h22, 1);
    add(0, 1, 0, 4'hF, D,  1, 4'h4, 1, 8'h33, 2);
    add(0, 1, 0, 4'hF, D,  1, 4'h8, 1, 8'h44, 3);
    add(0, 1, 0, 4'hF, D,  1, 4'h1, 1, 8'h11, 0);
    // fixed select sel=2
    add(0, 0, 2, 4'hF, D,  1, 4'h4, 1, 8'h33, 2);
    add(0, 0, 2, 4'hF, D,  1, 4'h4, 1, 8'h33, 2);
    add(0, 0, 2, 4'hB, D,  1, 4'h0, 0, 8'h33, 2);
    // sparse round-robin (last still 0, fixed mode left it alone)
    add(0, 1, 0, 4'hA, D,  1, 4'h2, 1, 8'h22, 1);
    add(0, 1, 0, 4'hA, D,  1, 4'h8, 1, 8'h44, 3);
    add(0, 1, 0, 4'hA, D,  1, 4'h2, 1, 8'h22, 1);
    add(0, 1, 0, 4'hA, D,  1, 4'h8, 1, 8'h44, 3);
    add(0, 1, 0, 4'h1, D,  1, 4'h1, 1, 8'h11, 0);
    // backpressure: load channel 1, then stall while inputs churn
    add(0, 1, 0, 4'h2, D,  1, 4'h2, 1, 8'h22, 1);
    add(0, 0, 0, 4'hF, D2, 0, 4'h0, 1, 8'h22, 1);
    add(0, 0, 1, 4'hF, D,  0, 4'h0, 1, 8'h22, 1);
    add(0, 0, 2, 4'hF, D2, 0, 4'h0, 1, 8'h22, 1);
    add(0, 1, 3, 4'hF, D,  0, 4'h0, 1, 8'h22, 1);
    add(0, 0, 3, 4'hF, D2, 0, 4'h0, 1, 8'h22, 1);
    // drain and refill in the same cycle
    add(0, 0, 3, 4'hF, D2, 1, 4'h8, 1, 8'hAA, 3);
    // mid-operation reset after a round-robin grant to channel 2
    add(0, 1, 0, 4'h4, D,  1, 4'h4, 1, 8'h33, 2);
    add(0, 1, 0, 4'hF, D,  0, 4'h0, 1, 8'h33, 2);
    add(1, 1, 0, 4'hF, D,  0, 4'h0, 0, 8'h00, 0);
    add(0, 1, 0, 4'hF, D,  1, 4'h1, 1, 8'h11, 0);
    // nothing valid: output empties, data/sel hold
    add(0, 1, 0, 4'h0, D,  1, 4'h0, 0, 8'h11, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].mode, tbl[i].sel, tbl[i].v, tbl[i].d, tbl[i].ordy);
      #1;
      check("in_ready", i, 32'(in_ready), 32'(tbl[i].eir));
      @(posedge clk);
      #1;
      check("out_valid", i, 32'(out_valid), 32'(tbl[i].eov));
      check("out_data",  i, 32'(out_data),  32'(tbl[i].eod));
      check("out_sel",   i, 32'(out_sel),   32'(tbl[i].eos));
    end

    // Fairness: after reset, continuous valid gives 0,1,2,3,0,1,2,3.
    drive(1'b1, 1'b1, 2'd0, 4'hF, D, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov", 100, 32'(out_valid), 32'd0);
    drive(1'b0, 1'b1, 2'd0, 4'hF, D, 1'b1);
    for (int i = 0; i < 2 * N; i++) begin
      #1;
      check("rr_ready", 200 + i, 32'(in_ready), 32'(4'b0001 << (i % N)));
      @(posedge clk);
      #1;
      check("rr_sel",  200 + i, 32'(out_sel),  32'(i % N));
      check("rr_data", 200 + i, 32'(out_data), (D >> (8 * (i % N))) & 32'hFF);
    end

    // Latency: a lone word on channel 2 appears one cycle later.
    drive(1'b0, 1'b1, 2'd0, 4'h0, D2, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("idle_ov", 300, 32'(out_valid), 32'd0);
    drive(1'b0, 1'b1, 2'd0, 4'h4, D2, 1'b1);
    got = -1;
    for (int c = 0; c < 4 && got < 0; c++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) got = c;
      in_valid = 4'h0;
    end
    check("latency", 301, 32'(got), 32'd0);
    check("lat_data", 302, 32'(out_data), 32'hBB);
    check("lat_sel",  303, 32'(out_sel),  32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
